// File: rtl/p2s_pkg.sv
// p2s_pkg: shared types for the parallel-to-serial converter.
//   word_t       one 32-bit data word
//   WORD_W       word width in bits
//   p2s_state_t  buffer occupancy state: EMPTY (no frame), SHIFT (active frame
//                draining), FULL (active draining, next frame parked in hold)
package p2s_pkg;
    localparam int WORD_W = 32;
    typedef logic [WORD_W-1:0] word_t;
    typedef enum logic [1:0] {P2S_EMPTY, P2S_SHIFT, P2S_FULL} p2s_state_t;
endpackage

// File: rtl/p2s_frame_reg.sv
// p2s_frame_reg: one frame of PARALLEL_LENGTH words with a load enable.
// Holds pure data, so it carries no reset.
//   clk  in   clock
//   ld   in   load d into q on this edge
//   d    in   [0:PARALLEL_LENGTH-1][WORD_W-1:0] frame to store
//   q    out  [0:PARALLEL_LENGTH-1][WORD_W-1:0] stored frame
module p2s_frame_reg
    import p2s_pkg::*;
#(
    parameter int PARALLEL_LENGTH = 32
) (
    input  logic                                   clk,
    input  logic                                   ld,
    input  logic [0:PARALLEL_LENGTH-1][WORD_W-1:0] d,
    output logic [0:PARALLEL_LENGTH-1][WORD_W-1:0] q
);

    always_ff @(posedge clk) begin
        if (ld) begin
            q <= d;
        end
    end

endmodule

// File: rtl/p2s_to_s_converter_top.sv
// p_to_s_converter: takes a whole frame of PARALLEL_LENGTH words in one cycle
// and emits it as SERIAL_LENGTH words per beat, word 0 first. An active frame
// drains while a second frame may wait in a hold slot.
// Optional feature: define P2S_OVF_EN to add the sticky ovf output, set on the
// cycle after a frame is offered while ordy is low, cleared only by rst.
//   clk    in   clock, all logic on posedge
//   rst    in   synchronous active-high reset
//   ien    in   input frame valid (accepted when ien & ordy)
//   idata  in   [0:PARALLEL_LENGTH-1][31:0] input frame
//   ordy   out  ready for a frame (hold slot empty)
//   oen    out  output beat valid
//   odata  out  [0:SERIAL_LENGTH-1][31:0] output beat
//   olast  out  last beat of a frame
//   irdy   in   downstream ready (beat moves when oen & irdy)
//   ovf    out  sticky overflow flag (P2S_OVF_EN only)
module p_to_s_converter
    import p2s_pkg::*;
#(
    parameter int SERIAL_LENGTH   = 1,
    parameter int PARALLEL_LENGTH = 32
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   ien,
    input  logic [0:PARALLEL_LENGTH-1][WORD_W-1:0] idata,
    output logic                                   ordy,
    output logic                                   oen,
    output logic [0:SERIAL_LENGTH-1][WORD_W-1:0]   odata,
    output logic                                   olast,
    input  logic                                   irdy
`ifdef P2S_OVF_EN
    ,
    output logic                                   ovf
`endif
);

    localparam int BEATS     = PARALLEL_LENGTH / SERIAL_LENGTH;
    localparam int CNT_W     = $clog2(BEATS) + 1;
    localparam int BEAT_BITS = SERIAL_LENGTH * WORD_W;
    localparam int FRAME_BITS = PARALLEL_LENGTH * WORD_W;

    if ((PARALLEL_LENGTH % SERIAL_LENGTH) != 0) begin : g_bad_len
        $error("p_to_s_converter: PARALLEL_LENGTH must be a multiple of SERIAL_LENGTH");
    end

    p2s_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              act_ld, hold_ld, act_from_hold;
    logic              beat, last;
    logic [0:PARALLEL_LENGTH-1][WORD_W-1:0] active_q, hold_q, active_d;
    logic [FRAME_BITS-1:0] frame_sh;
    logic [31:0]           shamt;

    // Outputs decode from registered state only.
    assign oen   = (state_q != P2S_EMPTY);
    assign ordy  = (state_q != P2S_FULL);
    assign last  = (cnt_q == CNT_W'(BEATS - 1));
    assign olast = oen & last;
    assign beat  = oen & irdy;

    // Word 0 sits at the MSB end of the packed frame, so shifting left by
    // cnt beats brings the current beat to the top.
    assign shamt    = 32'(cnt_q) * 32'(BEAT_BITS);
    assign frame_sh = active_q << shamt;
    assign odata    = frame_sh[FRAME_BITS-1 -: BEAT_BITS];

    assign active_d = act_from_hold ? hold_q : idata;

    p2s_frame_reg #(.PARALLEL_LENGTH(PARALLEL_LENGTH)) u_active (
        .clk (clk),
        .ld  (act_ld),
        .d   (active_d),
        .q   (active_q)
    );

    p2s_frame_reg #(.PARALLEL_LENGTH(PARALLEL_LENGTH)) u_hold (
        .clk (clk),
        .ld  (hold_ld),
        .d   (idata),
        .q   (hold_q)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        act_ld        = 1'b0;
        hold_ld       = 1'b0;
        act_from_hold = 1'b0;
        case (state_q)
            P2S_EMPTY: begin
                if (ien) begin
                    act_ld  = 1'b1;
                    cnt_d   = '0;
                    state_d = P2S_SHIFT;
                end
            end
            P2S_SHIFT: begin
                if (beat && !last) begin
                    cnt_d = cnt_q + 1'b1;
                    // ordy is high here, so a frame offered mid-drain is parked.
                    if (ien) begin
                        hold_ld = 1'b1;
                        state_d = P2S_FULL;
                    end
                end else if (beat) begin
                    cnt_d = '0;
                    if (ien) begin
                        act_ld = 1'b1;   // gapless hand-over to the next frame
                    end else begin
                        state_d = P2S_EMPTY;
                    end
                end else if (ien) begin
                    hold_ld = 1'b1;
                    state_d = P2S_FULL;
                end
            end
            P2S_FULL: begin
                if (beat && !last) begin
                    cnt_d = cnt_q + 1'b1;
                end else if (beat) begin
                    act_ld        = 1'b1;
                    act_from_hold = 1'b1;
                    cnt_d         = '0;
                    state_d       = P2S_SHIFT;
                end
            end
            default: begin
                state_d = P2S_EMPTY;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= P2S_EMPTY;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef P2S_OVF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (ien && !ordy) begin
            ovf <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_p_to_s_converter.sv
// Bench for p_to_s_converter: three configurations (S=1/P=4, S=2/P=8,
// S=4/P=4) run side by side; each is compared every cycle against a
// frame-queue model of the expected word stream.
module tb_p_to_s_converter;

    logic clk;
    int   n_chk  = 0;
    int   n_pass = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_cfg
        localparam int S     = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
        localparam int P     = (g == 1) ? 8 : 4;
        localparam int BEATS = P / S;

        logic rst, ien, irdy, ordy, oen, olast;
        logic [0:P-1][31:0] idata;
        logic [0:S-1][31:0] odata;
`ifdef P2S_OVF_EN
        logic ovf;
`endif
        bit fin = 1'b0;

        p_to_s_converter #(.SERIAL_LENGTH(S), .PARALLEL_LENGTH(P)) dut (
            .clk   (clk),
            .rst   (rst),
            .ien   (ien),
            .idata (idata),
            .ordy  (ordy),
            .oen   (oen),
            .odata (odata),
            .olast (olast),
            .irdy  (irdy)
`ifdef P2S_OVF_EN
            ,
            .ovf   (ovf)
`endif
        );

        // Reference model: expected output words in order, number of frames
        // accepted but not fully emitted, and beats already sent of the head frame.
        logic [31:0] expq[$];
        int  nfr   = 0;
        int  wpos  = 0;
        bit  ovf_m = 1'b0;
        bit  oen_m, ordy_m, olast_m;
        logic [S*32-1:0] obeat;
        logic [P*32-1:0] fin_word;

        always @(negedge clk) begin
            oen_m   = (nfr > 0);
            ordy_m  = (nfr < 2);
            olast_m = oen_m && (wpos == BEATS - 1);
            check($sformatf("c%0d_oen", g), 64'(oen), 64'(oen_m));
            check($sformatf("c%0d_ordy", g), 64'(ordy), 64'(ordy_m));
            check($sformatf("c%0d_olast", g), 64'(olast), 64'(olast_m));
            if (oen_m && expq.size() >= S) begin
                obeat = odata;
                for (int i = 0; i < S; i++) begin
                    check($sformatf("c%0d_odata%0d", g, i), 64'(obeat[S*32-1 -: 32]), 64'(expq[i]));
                    obeat = obeat << 32;
                end
            end
`ifdef P2S_OVF_EN
            check($sformatf("c%0d_ovf", g), 64'(ovf), 64'(ovf_m));
`endif
            // advance the model to what the coming edge does
            if (rst) begin
                expq.delete();
                nfr   = 0;
                wpos  = 0;
                ovf_m = 1'b0;
            end else begin
                if (ien && !ordy_m) ovf_m = 1'b1;
                if (oen_m && irdy) begin
                    for (int i = 0; i < S; i++) void'(expq.pop_front());
                    wpos++;
                    if (wpos == BEATS) begin
                        wpos = 0;
                        nfr--;
                    end
                end
                if (ien && ordy_m) begin
                    fin_word = idata;
                    for (int i = 0; i < P; i++) begin
                        expq.push_back(fin_word[P*32-1 -: 32]);
                        fin_word = fin_word << 32;
                    end
                    nfr++;
                end
            end
        end

        task automatic cyc();
            @(posedge clk);
            #1;
        endtask

        task automatic new_data();
            logic [P*32-1:0] t;
            t = '0;
            for (int i = 0; i < P; i++) t = {t[P*32-33:0], 32'($urandom)};
            idata = t;
        endtask

        task automatic put();
            ien = 1'b1;
            new_data();
            cyc();
            ien = 1'b0;
        endtask

        task automatic drain();
            int k;
            k = 0;
            irdy = 1'b1;
            ien  = 1'b0;
            while (oen && k < 200) begin
                cyc();
                k++;
            end
            if (oen) check($sformatf("c%0d_drain_timeout", g), 64'(1), 64'(0));
        endtask

        initial begin
            int k;
            rst   = 1'b1;
            ien   = 1'b0;
            irdy  = 1'b0;
            idata = '0;
            repeat (2) cyc();
            rst = 1'b0;
            cyc();

            // single frame, downstream always ready
            irdy = 1'b1;
            put();
            drain();

            // gapless: next frame offered during the last beat
            irdy = 1'b1;
            put();
            k = 0;
            while (!(oen && olast) && k < 50) begin
                cyc();
                k++;
            end
            ien = 1'b1;
            new_data();
            cyc();
            ien = 1'b0;
            drain();

            // stall on the second beat
            irdy = 1'b1;
            put();
            cyc();
            irdy = 1'b0;
            repeat (3) cyc();
            drain();

            // overflow: third frame arrives while FULL
            irdy = 1'b0;
            put();
            put();
            check($sformatf("c%0d_full_ordy", g), 64'(ordy), 64'(0));
            put();
            drain();

            // reset while FULL and draining
            irdy = 1'b0;
            put();
            put();
            irdy = 1'b1;
            cyc();
            rst = 1'b1;
            cyc();
            rst = 1'b0;
            check($sformatf("c%0d_rst_oen", g), 64'(oen), 64'(0));
            check($sformatf("c%0d_rst_ordy", g), 64'(ordy), 64'(1));
            put();
            drain();

            // a frame offered every cycle
            irdy = 1'b1;
            for (int i = 0; i < 12; i++) begin
                ien = 1'b1;
                new_data();
                cyc();
            end
            ien = 1'b0;
            drain();

            // random traffic with occasional reset
            for (int i = 0; i < 400; i++) begin
                rst  = ($urandom_range(99) == 0);
                ien  = $urandom_range(1) == 1;
                irdy = $urandom_range(9) < 7;
                new_data();
                cyc();
            end
            rst = 1'b0;
            drain();
            fin = 1'b1;
        end
    end

    initial begin
        int k;
        for (k = 0; k < 30000; k++) begin
            @(posedge clk);
            if (g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin) break;
        end
        if (!(g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin))
            check("global_timeout", 64'(0), 64'(1));
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
